// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD bus scheduler:
// FSM states, HD44780 init command bytes and init ROM lookup.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP   = 3'd0,
    ST_INIT_LOAD = 3'd1,
    ST_IDLE      = 3'd2,
    ST_SETUP     = 3'd3,
    ST_PULSE     = 3'd4,
    ST_HOLD      = 3'd5,
    ST_WAIT      = 3'd6
  } lcd_state_t;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_HOME     = 8'h02;

  localparam int INIT_LEN   = 32'sd4;
  localparam int INIT_IDX_W = 32'sd2;

  function automatic logic [7:0] init_rom(input logic [INIT_IDX_W-1:0] idx);
    logic [7:0] cmd_s;
    case (idx)
      2'd0:    cmd_s = LCD_FUNC_SET;
      2'd1:    cmd_s = LCD_DISP_ON;
      2'd2:    cmd_s = LCD_ENTRY;
      2'd3:    cmd_s = LCD_CLEAR;
      default: cmd_s = LCD_CLEAR;
    endcase
    return cmd_s;
  endfunction

  // Clear and home are the slow commands that need the long execution delay
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && ((data == LCD_CLEAR) || (data == LCD_HOME));
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter with a done flag, shared by every timed state of the
// LCD bus scheduler. A zero-length load behaves as a one-cycle delay.
module lcd_delay_timer #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] cnt_r;

  // Count down towards one; done marks the final cycle of the delay
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r <= (RST_VAL == ZERO) ? ONE : RST_VAL;
    end else if (load) begin
      cnt_r <= (load_val == ZERO) ? ONE : load_val;
    end else if (cnt_r != ZERO) begin
      cnt_r <= cnt_r - ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == ONE);

endmodule

// File: rtl/lcd_bus_scheduler.sv
// Character-LCD bus owner: HD44780 power-up init, then one-byte-at-a-time
// arbitration between two writers. Define LCD_SCHED_RR_EN for round-robin.
module lcd_bus_scheduler
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYC    = 1500000,
  parameter int E_PULSE_CYC    = 25,
  parameter int CMD_WAIT_CYC   = 4000,
  parameter int CLEAR_WAIT_CYC = 160000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       rs0,
  input  logic       rs1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic       E,
  output logic       RS,
  output logic       RW,
  output logic [7:0] DATA,
  output logic       busy,
  output logic       init_done
);

  localparam int MAX_PE  = (POWERUP_CYC > E_PULSE_CYC) ? POWERUP_CYC : E_PULSE_CYC;
  localparam int MAX_WT  = (CMD_WAIT_CYC > CLEAR_WAIT_CYC) ? CMD_WAIT_CYC : CLEAR_WAIT_CYC;
  localparam int MAX_CYC = (MAX_PE > MAX_WT) ? MAX_PE : MAX_WT;
  localparam int CNT_W   = $clog2(MAX_CYC) + 32'sd1;

  localparam logic [CNT_W-1:0] PWR_LD   = CNT_W'(POWERUP_CYC);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(E_PULSE_CYC);
  localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYC);
  localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLEAR_WAIT_CYC);
  localparam logic [INIT_IDX_W-1:0] INIT_LAST = INIT_IDX_W'(INIT_LEN - 32'sd1);

  lcd_state_t            state_r;
  logic                  e_r;
  logic                  rs_r;
  logic [7:0]            data_r;
  logic                  ack0_r;
  logic                  ack1_r;
  logic                  busy_r;
  logic                  init_done_r;
  logic [INIT_IDX_W-1:0] init_idx_r;

  logic                  tmr_load_s;
  logic [CNT_W-1:0]      tmr_val_s;
  logic                  tmr_done_s;
  logic                  any_req_s;
  logic                  win1_s;
  logic                  last_init_s;
  logic                  grant_now_s;

  lcd_delay_timer #(
    .WIDTH   (CNT_W),
    .RST_VAL (PWR_LD)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .done     (tmr_done_s)
  );

  assign any_req_s   = req0 | req1;
  assign last_init_s = (init_idx_r == INIT_LAST);

`ifdef LCD_SCHED_RR_EN
  logic ptr_r;

  // Round-robin: on contention the pointer names the preferred requester
  always_comb begin
    win1_s = 1'b0;
    if (req0 && req1) begin
      win1_s = ptr_r;
    end else begin
      win1_s = req1;
    end
  end

  // Hand preference to the requester that lost (or did not ask) this grant
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_r <= 1'b0;
    end else if (grant_now_s) begin
      ptr_r <= ~win1_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end
`else
  // Fixed priority: requester 1 only wins when requester 0 is quiet
  always_comb begin
    win1_s = 1'b0;
    if (req0) begin
      win1_s = 1'b0;
    end else begin
      win1_s = req1;
    end
  end
`endif

  // A grant happens in IDLE, or directly off the last WAIT cycle once init is over
  always_comb begin
    grant_now_s = 1'b0;
    if (!any_req_s) begin
      grant_now_s = 1'b0;
    end else if (state_r == ST_IDLE) begin
      grant_now_s = !ack0_r && !ack1_r;
    end else if (state_r == ST_WAIT) begin
      grant_now_s = tmr_done_s && (init_done_r || last_init_s);
    end else begin
      grant_now_s = 1'b0;
    end
  end

  // Timer reload on entry to PULSE and WAIT; POWERUP is loaded by reset
  always_comb begin
    tmr_load_s = 1'b0;
    tmr_val_s  = {CNT_W{1'b0}};
    case (state_r)
      ST_SETUP: begin
        tmr_load_s = 1'b1;
        tmr_val_s  = PULSE_LD;
      end
      ST_HOLD: begin
        tmr_load_s = 1'b1;
        tmr_val_s  = is_long_cmd(rs_r, data_r) ? CLR_LD : CMD_LD;
      end
      default: begin
        tmr_load_s = 1'b0;
        tmr_val_s  = {CNT_W{1'b0}};
      end
    endcase
  end

  // Main sequencer with registered bus, handshake and status outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_POWERUP;
      e_r         <= 1'b0;
      rs_r        <= 1'b0;
      data_r      <= 8'h00;
      ack0_r      <= 1'b0;
      ack1_r      <= 1'b0;
      busy_r      <= 1'b1;
      init_done_r <= 1'b0;
      init_idx_r  <= {INIT_IDX_W{1'b0}};
    end else begin
      ack0_r <= 1'b0;
      ack1_r <= 1'b0;
      case (state_r)
        ST_POWERUP: begin
          if (tmr_done_s) state_r <= ST_INIT_LOAD;
          else            state_r <= ST_POWERUP;
        end
        ST_INIT_LOAD: begin
          rs_r    <= 1'b0;
          data_r  <= init_rom(init_idx_r);
          state_r <= ST_SETUP;
        end
        ST_SETUP: begin
          e_r     <= 1'b1;
          state_r <= ST_PULSE;
        end
        ST_PULSE: begin
          if (tmr_done_s) begin
            e_r     <= 1'b0;
            state_r <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tmr_done_s) begin
            if (init_done_r || last_init_s) begin
              init_done_r <= 1'b1;
              busy_r      <= 1'b0;
              state_r     <= ST_IDLE;
            end else begin
              init_idx_r <= init_idx_r + 2'd1;
              state_r    <= ST_INIT_LOAD;
            end
          end
        end
        ST_IDLE: begin
          // The ack cycle is spent in IDLE; the transfer starts right after it
          if (ack0_r || ack1_r) begin
            busy_r  <= 1'b1;
            state_r <= ST_SETUP;
          end
        end
        default: begin
          state_r     <= ST_POWERUP;
          e_r         <= 1'b0;
          busy_r      <= 1'b1;
          init_done_r <= 1'b0;
          init_idx_r  <= {INIT_IDX_W{1'b0}};
        end
      endcase
      if (grant_now_s) begin
        ack0_r <= ~win1_s;
        ack1_r <= win1_s;
        rs_r   <= win1_s ? rs1 : rs0;
        data_r <= win1_s ? data1 : data0;
      end
    end
  end

  assign ack0      = ack0_r;
  assign ack1      = ack1_r;
  assign E         = e_r;
  assign RS        = rs_r;
  assign RW        = 1'b0;
  assign DATA      = data_r;
  assign busy      = busy_r;
  assign init_done = init_done_r;

endmodule

// File: doc/lcd_bus_scheduler.md
# lcd_bus_scheduler

Owns the character-LCD bus (E, RS, RW, DATA) of the digital clock design and shares it between two writers: the time/date line renderer (requester 0) and the mode/setting line renderer (requester 1). After reset it runs the HD44780 power-up init sequence autonomously. It then grants one byte transfer at a time, generates the E strobe and enforces per-command execution delays. It sits between the display-formatting logic and the top-level LCD pins.

## Interface
Parameters:
- POWERUP_CYC, 1500000, cycles idle after reset before first init command (15 ms at 100 MHz)
- E_PULSE_CYC, 25, E high width in cycles
- CMD_WAIT_CYC, 4000, post-strobe wait for ordinary commands/data (40 us)
- CLEAR_WAIT_CYC, 160000, post-strobe wait for clear (0x01) / home (0x02) commands (1.6 ms)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req0 / req1  in  1  transfer request, held until matching ack
- rs0 / rs1  in  1  register select for the requested byte (0 = command, 1 = data)
- data0 / data1  in  8  byte to write
- ack0 / ack1  out  1  one-cycle pulse; byte captured on this cycle
- E  out  1  LCD enable strobe
- RS  out  1  LCD register select
- RW  out  1  LCD read/write; always 0
- DATA  out  8  LCD data bus
- busy  out  1  high whenever not in IDLE
- init_done  out  1  high once init sequence completes, stays high until reset

## Operation
- Reset values: E=0, RS=0, RW=0, DATA=0x00, ack0=ack1=0, busy=1, init_done=0; FSM in POWERUP; grant pointer = requester 0.
- States: POWERUP -> INIT_LOAD -> SETUP -> PULSE -> HOLD -> WAIT -> (INIT_LOAD | IDLE).
- POWERUP: count POWERUP_CYC cycles, then INIT_LOAD.
- Init ROM, sent in order with RS=0: 0x38 (8-bit, 2 lines), 0x0C (display on, cursor off), 0x06 (increment), 0x01 (clear). After the 4th WAIT: init_done=1 and go to IDLE. Requests are ignored until init_done is set.
- IDLE: if any req, arbitrate, latch rs/data of the winner into RS/DATA, pulse the winner's ack for one cycle, then go to SETUP.
- SETUP: 1 cycle with RS/DATA stable and E=0 (address setup).
- PULSE: E=1 for exactly E_PULSE_CYC cycles.
- HOLD: E=0 for 1 cycle with RS/DATA unchanged (data hold).
- WAIT: count CLEAR_WAIT_CYC if the latched RS=0 and DATA ∈ {0x01, 0x02}, else CMD_WAIT_CYC. Then return to IDLE, or to INIT_LOAD while init is incomplete.
- RS/DATA change only on the grant cycle or INIT_LOAD; otherwise they hold their last value.
- Arbitration: see Configuration. Requests that arrive while busy wait; nothing is dropped, and a requester's req stays high until its ack.
- Delay counter: a single down-counter, width $clog2 of the largest parameter + 1, loaded on each state entry. A zero-length load is treated as 1.

## Timing
- Grant latency: ack is asserted in the first IDLE cycle where req is high. If the bus is already idle, that is the cycle after req rises (req is sampled on the clock edge).
- Per transfer, ack to next possible ack = 1 (SETUP) + E_PULSE_CYC + 1 (HOLD) + wait count + 1 (IDLE) cycles.
- E rises 2 cycles after ack.
- Simultaneous req0 and req1: exactly one ack per grant; the loser is granted after the winner's WAIT completes.
- Reset mid-transfer: E drops to 0 immediately (asynchronous). The init sequence restarts from POWERUP and the in-flight byte is lost.

## Configuration
- LCD_SCHED_RR_EN defined: round-robin arbitration. The pointer toggles to the non-granted requester after each grant, so under continuous contention grants alternate 0,1,0,1.
- LCD_SCHED_RR_EN undefined: fixed priority, requester 0 always wins. Requester 1 is served only when req0=0 in IDLE. The pointer logic is not built.

## Structure
- Shared package lcd_pkg: FSM state enum, init ROM constants (LCD_FUNC_SET=0x38, LCD_DISP_ON=0x0C, LCD_ENTRY=0x06, LCD_CLEAR=0x01, LCD_HOME=0x02), INIT_LEN=4.
- One sub-module, lcd_delay_timer: loadable down-counter with a done flag, parameterised width, used for every timed state.

## Test plan
Test with parameters overridden to POWERUP_CYC=100, E_PULSE_CYC=3, CMD_WAIT_CYC=10, CLEAR_WAIT_CYC=40.
- Reset release, no requests -> E pulses carrying DATA 0x38, 0x0C, 0x06, 0x01 with RS=0, RW=0; each pulse is 3 cycles wide; 40-cycle gap after 0x01; init_done rises; busy falls.
- req0 held high during init -> no ack until init_done. Then ack0 is asserted in the first IDLE cycle and E rises 2 cycles later with DATA=data0.
- req0 with rs0=1, data0=0x41 -> RS=1, DATA=0x41 during E; next grant no earlier than 3+1+1+10+1 cycles after ack.
- req0 and req1 both held for 4 transfers -> with LCD_SCHED_RR_EN, ack order 0,1,0,1; without it, ack order 0,0,0,0 and req1 starves.
- Command 0x01 via req1 -> 40-cycle WAIT; command 0x80 -> 10-cycle WAIT.
- reset asserted while E=1 -> E, ack and init_done go to 0 immediately; the init sequence replays from the start.
